// File: rtl/instruction_loader_pkg.sv
// Shared IF-stage loader constants and FSM state encodings.
// The CHK state exists only when INSTRUCTION_LOADER_CHECKSUM_EN is defined.
package instruction_loader_pkg;

    localparam int          WORD_BYTES    = 4;
    localparam logic [31:0] BASE_ADDR_DEF = 32'd0;

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {HDR_LO, HDR_HI, DATA, CHK, DONE} ld_state_e;
`else
    typedef enum logic [2:0] {HDR_LO, HDR_HI, DATA, DONE} ld_state_e;
`endif

endpackage

// File: rtl/instruction_loader_if.sv
// Byte-stream input, instruction RAM write port and load status of the loader.
interface instruction_loader_if;

    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        restart;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        core_hold;
    logic        load_done;
    logic        load_err;

    modport slave (
        input  rx_valid, rx_data, restart,
        output rx_ready, mem_we, mem_addr, mem_wdata, core_hold, load_done, load_err
    );

    modport master (
        output rx_valid, rx_data, restart,
        input  rx_ready, mem_we, mem_addr, mem_wdata, core_hold, load_done, load_err
    );

endinterface

// File: rtl/instruction_loader_word_assembler.sv
// Collects little-endian stream bytes into a 32-bit word; word_o is valid with done_o.
module loader_word_assembler
    import instruction_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr_i,
    input  logic        take_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        done_o
);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] asm_q, asm_d;

    // The final byte bypasses the register so the word is ready on its handshake cycle.
    assign done_o = take_i && (idx_q == 2'(WORD_BYTES - 1));
    assign word_o = {byte_i, asm_q};

    always_comb begin
        idx_d = idx_q;
        asm_d = asm_q;
        if (clr_i) begin
            idx_d = 2'd0;
            asm_d = 24'd0;
        end else if (take_i) begin
            idx_d = idx_q + 2'd1;
            case (idx_q)
                2'd0:    asm_d[7:0]   = byte_i;
                2'd1:    asm_d[15:8]  = byte_i;
                2'd2:    asm_d[23:16] = byte_i;
                default: asm_d        = asm_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 2'd0;
            asm_q <= 24'd0;
        end else begin
            idx_q <= idx_d;
            asm_q <= asm_d;
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Loads a length-prefixed byte stream into instruction RAM while holding the core in reset.
// Define INSTRUCTION_LOADER_CHECKSUM_EN to add a trailing XOR checksum byte (CHK state).
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instruction_loader_if.slave  bus
);

    localparam logic [16:0] DEPTH     = 17'(1) << ADDR_W;
    localparam logic [31:0] LAST_ADDR = BASE_ADDR + ((32'(DEPTH) - 32'd1) << 2);
    localparam logic [31:0] STEP      = 32'(WORD_BYTES);

    ld_state_e   state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [15:0] cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic        xfer, asm_clr, asm_take, word_done;
    logic [31:0] word;
    logic [15:0] n_hdr;

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    logic [7:0]  xor_q, xor_d;
    localparam ld_state_e ST_TAIL = CHK;
`else
    localparam ld_state_e ST_TAIL = DONE;
`endif

    assign bus.rx_ready  = rst_n && (state_q != DONE);
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.core_hold = (state_q != DONE);
    assign bus.load_done = (state_q == DONE);
    assign bus.load_err  = err_q;

    assign xfer  = bus.rx_valid && bus.rx_ready;
    assign n_hdr = {bus.rx_data, n_q[7:0]};

    loader_word_assembler u_asm (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (asm_clr),
        .take_i (asm_take),
        .byte_i (bus.rx_data),
        .word_o (word),
        .done_o (word_done)
    );

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        asm_clr  = 1'b0;
        asm_take = 1'b0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        xor_d    = xor_q;
`endif
        // Address steps after each write pulse and parks on the last RAM word.
        if (we_q && (addr_q != LAST_ADDR))
            addr_d = addr_q + STEP;

        case (state_q)
            HDR_LO: begin
                if (xfer) begin
                    n_d[7:0] = bus.rx_data;
                    state_d  = HDR_HI;
                end
            end
            HDR_HI: begin
                if (xfer) begin
                    n_d[15:8] = bus.rx_data;
                    if ({1'b0, n_hdr} > DEPTH)
                        err_d = 1'b1;
                    state_d = (n_hdr == 16'd0) ? ST_TAIL : DATA;
                end
            end
            DATA: begin
                asm_take = xfer;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                if (xfer)
                    xor_d = xor_q ^ bus.rx_data;
`endif
                if (word_done) begin
                    wdata_d = word;
                    we_d    = ({1'b0, cnt_q} < DEPTH);
                    cnt_d   = cnt_q + 16'd1;
                    if (cnt_q == n_q - 16'd1)
                        state_d = ST_TAIL;
                end
            end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            CHK: begin
                if (xfer) begin
                    if (bus.rx_data != xor_q)
                        err_d = 1'b1;
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                if (bus.restart) begin
                    state_d = HDR_LO;
                    err_d   = 1'b0;
                    addr_d  = BASE_ADDR;
                    n_d     = 16'd0;
                    cnt_d   = 16'd0;
                    asm_clr = 1'b1;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
                    xor_d   = 8'd0;
`endif
                end
            end
            default: state_d = HDR_LO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HDR_LO;
            n_q     <= 16'd0;
            cnt_q   <= 16'd0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            xor_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: two instances (ADDR_W=8 and ADDR_W=1).
// Checksum cases run when INSTRUCTION_LOADER_CHECKSUM_EN is defined.
module tb_instruction_loader;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] cyc;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        vld = 1'b0;
    logic [7:0]  dat = 8'd0;
    logic        restart = 1'b0;
    logic [31:0] cyc = 32'd0;
    int          n_chk = 0;
    int          n_err = 0;
    wr_t         wq[$];
    logic [31:0] acc[$];

    instruction_loader_if bus0();
    instruction_loader_if bus1();

    assign bus0.rx_valid = vld && !sel;
    assign bus0.rx_data  = dat;
    assign bus0.restart  = restart;
    assign bus1.rx_valid = vld && sel;
    assign bus1.rx_data  = dat;
    assign bus1.restart  = restart;

    instruction_loader #(.ADDR_W(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    instruction_loader #(.ADDR_W(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    wire        o_ready = sel ? bus1.rx_ready  : bus0.rx_ready;
    wire        o_we    = sel ? bus1.mem_we    : bus0.mem_we;
    wire [31:0] o_addr  = sel ? bus1.mem_addr  : bus0.mem_addr;
    wire [31:0] o_wdata = sel ? bus1.mem_wdata : bus0.mem_wdata;
    wire        o_hold  = sel ? bus1.core_hold : bus0.core_hold;
    wire        o_done  = sel ? bus1.load_done : bus0.load_done;
    wire        o_err   = sel ? bus1.load_err  : bus0.load_err;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;
    always @(negedge clk) if (o_we) wq.push_back('{o_addr, o_wdata, cyc});

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] b[$]);
        logic [7:0] x = 8'd0;
        for (int i = 2; i < b.size(); i++) x ^= b[i];
        return x;
    endfunction

    // Drives bytes starting #1 after a rising edge; acc logs the cycle of each handshake.
    task automatic send(input logic [7:0] b[$], input bit toggle);
        int  i = 0;
        int  guard = 0;
        bit  ph = 1'b0;
        bit  taken;
        while (i < b.size() && guard < 400) begin
            if (toggle && ph) vld = 1'b0;
            else begin vld = 1'b1; dat = b[i]; end
            @(negedge clk);
            taken = vld && o_ready;
            @(posedge clk); #1;
            if (taken) begin acc.push_back(cyc); i++; end
            ph = ~ph;
            guard++;
        end
        vld = 1'b0;
        if (i < b.size()) chk("send_timeout", 32'(i), 32'(b.size()));
    endtask

    task automatic load(input logic [7:0] b[$], input bit toggle);
        logic [7:0] s[$];
        s = b;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        s.push_back(xsum(b));
`endif
        send(s, toggle);
    endtask

    task automatic check_writes(input string tag, input logic [31:0] ea[$], input logic [31:0] ed[$]);
        chk({tag, "_count"}, 32'(wq.size()), 32'(ea.size()));
        for (int j = 0; j < ea.size() && j < wq.size(); j++) begin
            chk($sformatf("%s_addr%0d", tag, j), wq[j].addr, ea[j]);
            chk($sformatf("%s_data%0d", tag, j), wq[j].data, ed[j]);
            if (2 + 4*j + 3 < acc.size())
                chk($sformatf("%s_lat%0d", tag, j), wq[j].cyc, acc[2 + 4*j + 3]);
        end
    endtask

    task automatic clear_logs();
        wq.delete();
        acc.delete();
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(posedge clk); #1;
        restart = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    logic [7:0] prog[$] = '{8'h02, 8'h00, 8'h14, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h1A, 8'hA0, 8'hE3};

    initial begin
        #3;
        chk("rst_ready", 32'(o_ready), 0);
        chk("rst_we",    32'(o_we), 0);
        chk("rst_addr",  o_addr, 32'd0);
        chk("rst_wdata", o_wdata, 32'd0);
        chk("rst_hold",  32'(o_hold), 1);
        chk("rst_done",  32'(o_done), 0);
        chk("rst_err",   32'(o_err), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Two words, valid held high.
        clear_logs();
        load(prog, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_writes("a", '{32'd0, 32'd4}, '{32'hE3A00014, 32'hE3A01A01});
        chk("a_done",  32'(o_done), 1);
        chk("a_hold",  32'(o_hold), 0);
        chk("a_err",   32'(o_err), 0);
        chk("a_ready", 32'(o_ready), 0);

        pulse_restart();
        chk("rs_hold", 32'(o_hold), 1);
        chk("rs_done", 32'(o_done), 0);
        chk("rs_addr", o_addr, 32'd0);

        // Same program with valid toggling.
        clear_logs();
        load(prog, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check_writes("b", '{32'd0, 32'd4}, '{32'hE3A00014, 32'hE3A01A01});
        chk("b_done", 32'(o_done), 1);

        // Empty program straight after reset.
        pulse_reset();
        clear_logs();
        load('{8'h00, 8'h00}, 1'b0);
        chk("c_done", 32'(o_done), 1);
        chk("c_err",  32'(o_err), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("c_writes", 32'(wq.size()), 0);

        // Overflow on the two-word instance.
        sel = 1'b1;
        clear_logs();
        load('{8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
               8'h09, 8'h0A, 8'h0B, 8'h0C}, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_writes("d", '{32'd0, 32'd4}, '{32'h04030201, 32'h08070605});
        chk("d_err",  32'(o_err), 1);
        chk("d_done", 32'(o_done), 1);
        chk("d_addr", o_addr, 32'd4);
        sel = 1'b0;

        // Reset in the middle of the first word.
        pulse_reset();
        clear_logs();
        send('{8'h01, 8'h00, 8'hAA, 8'hBB}, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("e_ready", 32'(o_ready), 0);
        chk("e_hold",  32'(o_hold), 1);
        chk("e_done",  32'(o_done), 0);
        chk("e_we",    32'(o_we), 0);
        chk("e_addr",  o_addr, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_logs();
        load('{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12}, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_writes("e", '{32'd0}, '{32'h12345678});
        chk("e_fin_done", 32'(o_done), 1);

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        pulse_reset();
        clear_logs();
        send('{8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F}, 1'b0);
        @(posedge clk); #1;
        chk("k_good_err",  32'(o_err), 0);
        chk("k_good_done", 32'(o_done), 1);
        check_writes("k", '{32'd0}, '{32'h08040201});
        pulse_restart();
        clear_logs();
        send('{8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E}, 1'b0);
        @(posedge clk); #1;
        chk("k_bad_err",  32'(o_err), 1);
        chk("k_bad_done", 32'(o_done), 1);
        pulse_restart();
        chk("k_rs_err",  32'(o_err), 0);
        chk("k_rs_hold", 32'(o_hold), 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Writer side of the fetch-stage instruction memory: receives a program as a byte stream and writes 32-bit words into a writable instruction RAM.
- Words are written at word-aligned byte addresses, so the IF stage reads them back at {pc[31:2],2'b00}.
- Holds the core in reset while a program loads and releases it when the load completes.

Parameters:
- ADDR_W, 8, word-address width; RAM depth is 2^ADDR_W words.
- BASE_ADDR, 32'd0, byte address of the first word written; must be a multiple of 4.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- rx_valid  input  1  a byte is offered on rx_data.
- rx_data  input  8  stream byte.
- rx_ready  output  1  loader can accept a byte; a byte transfers on any cycle with rx_valid && rx_ready.
- restart  input  1  single-cycle request to begin a new load; sampled only in DONE.
- mem_we  output  1  one-cycle write strobe to the instruction RAM.
- mem_addr  output  32  byte address, word aligned (bits [1:0] always 0).
- mem_wdata  output  32  instruction word.
- core_hold  output  1  high while loading; the core is kept in reset.
- load_done  output  1  high in DONE.
- load_err  output  1  sticky error flag; cleared by restart or reset.

Behaviour:
- Stream format:
  - 2-byte word count N, low byte first.
  - Then N words of 4 bytes each, little-endian: the first byte goes to [7:0], the last to [31:24].
- Reset values:
  - state=HDR_LO; mem_we=0; mem_addr=BASE_ADDR; mem_wdata=0; core_hold=1; load_done=0; load_err=0.
  - Byte index, word counter and N cleared.
  - rx_ready=0 while rst_n is low.
- States:
  - HDR_LO: accept byte into N[7:0], go to HDR_HI.
  - HDR_HI: accept byte into N[15:8].
    - If N==0, go to DONE (CHK when the optional feature is enabled).
    - Otherwise go to DATA.
  - DATA:
    - Accept bytes into the 4-byte assembly register using a 2-bit byte index.
    - On the 4th byte, the assembled word is registered to mem_wdata and mem_we=1 on the following cycle; write latency is 1 cycle after the last byte's handshake.
    - mem_addr advances by 4 on the cycle after each write.
    - After word N is accepted, go to DONE (or CHK).
  - DONE:
    - rx_ready=0; load_done=1; core_hold=0.
    - restart=1: go to HDR_LO, core_hold=1, load_done=0, load_err=0, mem_addr=BASE_ADDR.
- rx_ready is 1 in HDR_LO, HDR_HI, DATA and CHK.
- No stall: a new byte may be accepted on every cycle, including the cycle mem_we is high.
- Overflow, N > 2^ADDR_W:
  - load_err is set in HDR_HI.
  - Words beyond the depth are consumed with mem_we suppressed.
  - mem_addr saturates at the last valid address.
- The word counter is 16 bits wide.
- restart outside DONE is ignored.
- rst_n asserted mid-load aborts immediately:
  - A partially assembled word is discarded.
  - Words already written are not rolled back.
  - core_hold returns to 1.

Optional Feature:
- Macro: INSTRUCTION_LOADER_CHECKSUM_EN.
- Enabled:
  - After the last data word (or after the header when N==0), state CHK accepts one trailer byte.
  - The trailer is compared with the XOR of all data bytes, excluding the header.
  - On mismatch, load_err is set; in both cases the loader then goes to DONE.
  - The running XOR is cleared on reset and on restart.
- Disabled: no CHK state and no XOR register; HDR_HI/DATA go straight to DONE.

Decomposition:
- Shared package (IF-stage constants): state encodings HDR_LO/HDR_HI/DATA/CHK/DONE, WORD_BYTES=4, and the BASE_ADDR default.
- One sub-module: loader_word_assembler, holding the byte index, the shift/assembly register and the word-complete pulse.
- The FSM and address counter stay in the top level.

Test Plan:
- Stream 02 00 | 14 00 A0 E3 | 01 1A A0 E3, rx_valid held high:
  - mem_we pulses twice: addr 0 data 32'hE3A00014, then addr 4 data 32'hE3A01A01.
  - Each pulse comes 1 cycle after the word's 4th byte.
  - load_done=1 and core_hold=0 after the last pulse.
- Same stream with rx_valid toggling 1/0 every cycle:
  - Identical writes and addresses.
  - No byte is accepted while rx_valid=0.
- Header 00 00 -> no mem_we; DONE reached two accepted bytes after reset; load_err=0.
- ADDR_W=1, header 03 00 plus 12 data bytes:
  - Writes occur only at addr 0 and addr 4.
  - Third word consumed with no write; load_err=1; DONE reached.
- rst_n pulled low after 2 of 4 bytes of word 1:
  - Outputs return to reset values; core_hold=1.
  - A fresh 01 00 | 78 56 34 12 stream then writes addr 0 data 32'h12345678.
- With CHECKSUM_EN, stream 01 00 | 01 02 04 08:
  - Trailer 0F -> load_err=0.
  - Trailer 0E -> load_err=1.
  - In DONE, a restart pulse clears load_err and core_hold returns to 1.
